// File: rtl/axi_mst_arbiter_pkg.sv
// Shared types and AXI constants for the core master-port arbiter.
// Imported by axi_mst_arbiter and arb_pick2.
package axi_mst_arbiter_pkg;

  localparam int AXI_ID_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_AR,
    ST_RD_R,
    ST_WR_AW_W,
    ST_WR_B
  } arb_state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } arb_gnt_e;

  localparam logic [AXI_ID_W-1:0] IFU_ID_DEFAULT  = 4'd0;
  localparam logic [AXI_ID_W-1:0] LSU_ID_DEFAULT  = 4'd1;
  localparam logic [1:0]          AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]          AXI_RESP_SLVERR = 2'b10;
  localparam logic [2:0]          AXI_SIZE_WORD   = 3'b010;
  localparam logic [7:0]          AXI_LEN_SINGLE  = 8'd0;

  function automatic logic [AXI_ID_W-1:0] grant_id(input arb_gnt_e g,
                                                  input logic [AXI_ID_W-1:0] ifu_id,
                                                  input logic [AXI_ID_W-1:0] lsu_id);
    return (g == GNT_LSU) ? lsu_id : ifu_id;
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Two-way picker: req_i[1] is LSU, req_i[0] is IFU. On conflict the side not
// named by last_i wins, so tying last_i low gives fixed LSU priority.
module arb_pick2
  import axi_mst_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       gnt_o
);

  assign valid_o = |req_i;
  assign gnt_o   = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/axi_mst_arbiter.sv
// Shares the core AXI4 master port between IFU (reads) and LSU (reads/writes),
// one single-beat transaction at a time. Define ARB_RR_EN for round-robin IFU/LSU.
module axi_mst_arbiter
  import axi_mst_arbiter_pkg::*;
#(
  parameter int                   ADDR_W = 32,
  parameter int                   DATA_W = 32,
  parameter logic [AXI_ID_W-1:0]  IFU_ID = IFU_ID_DEFAULT,
  parameter logic [AXI_ID_W-1:0]  LSU_ID = LSU_ID_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // IFU read port
  input  logic                  f_ar_valid_i,
  output logic                  f_ar_ready_o,
  input  logic [ADDR_W-1:0]     f_ar_addr_i,
  output logic                  f_r_valid_o,
  input  logic                  f_r_ready_i,
  output logic [DATA_W-1:0]     f_r_data_o,
  output logic [1:0]            f_r_resp_o,
  // LSU read port
  input  logic                  m_ar_valid_i,
  output logic                  m_ar_ready_o,
  input  logic [ADDR_W-1:0]     m_ar_addr_i,
  input  logic [2:0]            m_ar_size_i,
  output logic                  m_r_valid_o,
  input  logic                  m_r_ready_i,
  output logic [DATA_W-1:0]     m_r_data_o,
  output logic [1:0]            m_r_resp_o,
  // LSU write port
  input  logic                  m_aw_valid_i,
  output logic                  m_aw_ready_o,
  input  logic [ADDR_W-1:0]     m_aw_addr_i,
  input  logic [2:0]            m_aw_size_i,
  input  logic                  m_w_valid_i,
  output logic                  m_w_ready_o,
  input  logic [DATA_W-1:0]     m_w_data_i,
  input  logic [DATA_W/8-1:0]   m_w_strb_i,
  output logic                  m_b_valid_o,
  input  logic                  m_b_ready_i,
  output logic [1:0]            m_b_resp_o,
  // Core AXI4 master pins
  input  logic                  io_master_awready_i,
  output logic                  io_master_awvalid_o,
  output logic [ADDR_W-1:0]     io_master_awaddr_o,
  output logic [AXI_ID_W-1:0]   io_master_awid_o,
  output logic [7:0]            io_master_awlen_o,
  output logic [2:0]            io_master_awsize_o,
  output logic [1:0]            io_master_awburst_o,
  input  logic                  io_master_wready_i,
  output logic                  io_master_wvalid_o,
  output logic [DATA_W-1:0]     io_master_wdata_o,
  output logic [DATA_W/8-1:0]   io_master_wstrb_o,
  output logic                  io_master_wlast_o,
  output logic                  io_master_bready_o,
  input  logic                  io_master_bvalid_i,
  input  logic [1:0]            io_master_bresp_i,
  input  logic [AXI_ID_W-1:0]   io_master_bid_i,
  input  logic                  io_master_arready_i,
  output logic                  io_master_arvalid_o,
  output logic [ADDR_W-1:0]     io_master_araddr_o,
  output logic [AXI_ID_W-1:0]   io_master_arid_o,
  output logic [7:0]            io_master_arlen_o,
  output logic [2:0]            io_master_arsize_o,
  output logic [1:0]            io_master_arburst_o,
  output logic                  io_master_rready_o,
  input  logic                  io_master_rvalid_i,
  input  logic [1:0]            io_master_rresp_i,
  input  logic [DATA_W-1:0]     io_master_rdata_i,
  input  logic                  io_master_rlast_i,
  input  logic [AXI_ID_W-1:0]   io_master_rid_i
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e            state_q;
  arb_gnt_e              gnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2:0]            size_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  arvalid_q;
  logic                  awvalid_q;
  logic                  wvalid_q;

  logic [1:0]            pick_req;
  logic                  pick_last;
  logic                  pick_valid;
  logic                  pick_gnt;

  logic                  in_rd_r;
  logic                  in_wr_b;
  logic                  ar_hs;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  r_hs;
  logic                  b_hs;
  logic [AXI_ID_W-1:0]   gnt_id;
  logic [1:0]            rresp_eff;
  logic                  unused_ok;

  // A pending LSU write or read both count as one LSU request to the picker.
  assign pick_req = {m_aw_valid_i | m_ar_valid_i, f_ar_valid_i};

`ifdef ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && pick_valid) begin
      last_q <= pick_gnt;
    end
  end

  assign pick_last = last_q;
`else
  assign pick_last = 1'b0;
`endif

  arb_pick2 u_pick (
    .req_i   (pick_req),
    .last_i  (pick_last),
    .valid_o (pick_valid),
    .gnt_o   (pick_gnt)
  );

  assign in_rd_r = (state_q == ST_RD_R);
  assign in_wr_b = (state_q == ST_WR_B);
  assign ar_hs   = arvalid_q & io_master_arready_i;
  assign aw_hs   = awvalid_q & io_master_awready_i;
  assign w_hs    = wvalid_q & io_master_wready_i;
  assign r_hs    = io_master_rvalid_i & io_master_rready_o;
  assign b_hs    = io_master_bvalid_i & io_master_bready_o;
  assign gnt_id  = grant_id(gnt_q, IFU_ID, LSU_ID);

  // A channel's valid register dropping doubles as its "done" flag in WR_AW_W.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= GNT_IFU;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q <= arb_gnt_e'(pick_gnt);
            if (!pick_gnt) begin
              addr_q    <= f_ar_addr_i;
              size_q    <= AXI_SIZE_WORD;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_AR;
            end else if (m_aw_valid_i) begin
              addr_q    <= m_aw_addr_i;
              size_q    <= m_aw_size_i;
              wdata_q   <= m_w_data_i;
              wstrb_q   <= m_w_strb_i;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_AW_W;
            end else begin
              addr_q    <= m_ar_addr_i;
              size_q    <= m_ar_size_i;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_AR;
            end
          end
        end
        ST_RD_AR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (r_hs) begin
            state_q <= ST_IDLE;
          end
        end
        ST_WR_AW_W: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
          end
          if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
            state_q <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (b_hs) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_master_arvalid_o = arvalid_q;
  assign io_master_araddr_o  = addr_q;
  assign io_master_arid_o    = gnt_id;
  assign io_master_arlen_o   = AXI_LEN_SINGLE;
  assign io_master_arsize_o  = size_q;
  assign io_master_arburst_o = AXI_BURST_INCR;

  assign io_master_awvalid_o = awvalid_q;
  assign io_master_awaddr_o  = addr_q;
  assign io_master_awid_o    = LSU_ID;
  assign io_master_awlen_o   = AXI_LEN_SINGLE;
  assign io_master_awsize_o  = size_q;
  assign io_master_awburst_o = AXI_BURST_INCR;

  assign io_master_wvalid_o  = wvalid_q;
  assign io_master_wdata_o   = wdata_q;
  assign io_master_wstrb_o   = wstrb_q;
  assign io_master_wlast_o   = 1'b1;

  assign f_ar_ready_o = ar_hs & (gnt_q == GNT_IFU);
  assign m_ar_ready_o = ar_hs & (gnt_q == GNT_LSU);
  assign m_aw_ready_o = aw_hs;
  assign m_w_ready_o  = w_hs;

  // A response carrying someone else's ID is reported to the granted side as SLVERR.
  assign rresp_eff = (io_master_rid_i != gnt_id) ? AXI_RESP_SLVERR : io_master_rresp_i;

  assign io_master_rready_o = in_rd_r & ((gnt_q == GNT_LSU) ? m_r_ready_i : f_r_ready_i);
  assign f_r_valid_o        = in_rd_r & (gnt_q == GNT_IFU) & io_master_rvalid_i;
  assign m_r_valid_o        = in_rd_r & (gnt_q == GNT_LSU) & io_master_rvalid_i;
  assign f_r_data_o         = io_master_rdata_i;
  assign m_r_data_o         = io_master_rdata_i;
  assign f_r_resp_o         = rresp_eff;
  assign m_r_resp_o         = rresp_eff;

  assign io_master_bready_o = in_wr_b & m_b_ready_i;
  assign m_b_valid_o        = in_wr_b & io_master_bvalid_i;
  assign m_b_resp_o         = io_master_bresp_i;

  assign unused_ok = ^{m_w_valid_i, io_master_rlast_i, io_master_bid_i};

endmodule
